ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
Tic-tac-toe game controller. It sits directly downstream of the per-player move validator and consumes the validated (row, col) moves it produces. It owns the authoritative 3x3 board, applies moves, alternates turns, detects win/draw and publishes the board back to the validator and display.

Parameters:
FIRST_PLAYER, 0, player code (0=X, 1=O) that moves first after reset/new_game
CHECK_OCCUPIED, 1, when 1, re-check target cell emptiness before writing; reject occupied cells

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
new_game  input  1  synchronous clear to start position; takes priority over all other inputs
move_vld  input  1  validator presents a move
move_row  input  2  row 0-2
move_col  input  2  col 0-2
move_rdy  output  1  controller can accept a move (high only in WAIT_MOVE)
move_err  output  1  1-cycle pulse: accepted move rejected (out of range or occupied)
board_flat  output  18  cell i=row*3+col at bits [2i+1:2i]; 0=X, 1=O, 2=empty
turn  output  1  player to move
game_over  output  1  level, high in DONE
winner  output  2  0=X, 1=O, 2=draw, 3=none/in progress
move_cnt  output  4  cells filled, 0-9

Behaviour:
- Reset (rst_n low, async): all cells = 2, turn = FIRST_PLAYER, move_cnt = 0, winner = 3, game_over = 0, move_err = 0, state = WAIT_MOVE, move_rdy = 1 after release.
- new_game high at an edge: same values as reset, from any state, including mid-APPLY/CHECK; any captured move is discarded.
- States: WAIT_MOVE, APPLY, CHECK, DONE.
- WAIT_MOVE: move_rdy = 1. On move_vld&move_rdy at edge N, capture row/col and go to APPLY. move_vld without move_rdy is ignored; no queueing.
- APPLY (cycle N+1), move_rdy = 0:
  - If row>2 or col>2, or (CHECK_OCCUPIED and cell != 2): pulse move_err in cycle N+2, leave board/turn/move_cnt unchanged, return to WAIT_MOVE.
  - Otherwise write turn code into the cell, move_cnt += 1, go to CHECK. Board visible at N+2.
- CHECK (cycle N+2): evaluate the 8 lines (3 rows, 3 cols, 2 diagonals) for the current turn's code only.
  - Win: winner = turn, go to DONE.
  - Else if move_cnt == 9: winner = 2 (draw), go to DONE.
  - Else toggle turn, go to WAIT_MOVE.
  - A win on the 9th move reports the winner, not a draw.
- Move-to-result latency: result updated at edge ending N+2. Next move can be accepted at cycle N+3.
- DONE: game_over = 1, move_rdy = 0, board frozen, move_vld ignored; exit only via new_game or reset.
- move_cnt saturates at 9. The turn toggle never happens on the transition into DONE.
- Illegal state encoding: recover to WAIT_MOVE with board unchanged.

Decomposition:
- Package ttt_pkg: cell codes CELL_X=2'd0, CELL_O=2'd1, CELL_EMPTY=2'd2; winner codes WIN_X/WIN_O/WIN_DRAW/WIN_NONE; state enum; MAX_MOVES=9; cell_idx(row,col) function.
- Sub-module ttt_line_check: combinational, inputs board_flat[17:0] and player[1:0], output win[0]. Checks the 8 lines. Shared later by an AI move generator.

Test Plan:
- Reset, then X plays (0,0), O plays (1,1), X plays (0,1), O plays (2,2), X plays (0,2) -> after the last move's N+2, winner=0, game_over=1, move_cnt=5, turn stays 0.
- X (1,1) accepted, then O targets (1,1) -> move_err pulse exactly 1 cycle, board cell 4 stays 0, turn stays 1, move_cnt=1.
- move_row=3, move_col=0 -> move_err pulse, no board change, move_rdy back high at N+2.
- Full drawn game X(0,0) O(0,1) X(0,2) O(1,1) X(1,0) O(1,2) X(2,1) O(2,0) X(2,2) -> winner=2, move_cnt=9, game_over=1.
- Hold move_vld during APPLY/CHECK and during DONE -> no extra moves taken; new_game in DONE -> board all 2, winner=3, turn=FIRST_PLAYER next cycle.
- Assert rst_n low mid-CHECK -> outputs take reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe controller: cell codes, result codes,
// FSM states and board indexing.
package ttt_pkg;

    localparam logic [1:0] CELL_X     = 2'd0;
    localparam logic [1:0] CELL_O     = 2'd1;
    localparam logic [1:0] CELL_EMPTY = 2'd2;

    localparam logic [1:0] WIN_X    = 2'd0;
    localparam logic [1:0] WIN_O    = 2'd1;
    localparam logic [1:0] WIN_DRAW = 2'd2;
    localparam logic [1:0] WIN_NONE = 2'd3;

    localparam logic [3:0]  MAX_MOVES   = 4'd9;
    localparam logic [17:0] BOARD_EMPTY = {9{CELL_EMPTY}};

    typedef enum logic [1:0] {
        S_WAIT_MOVE = 2'd0,
        S_APPLY     = 2'd1,
        S_CHECK     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // Caller must range-check row/col; the result only names a cell for 0-2.
    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for one player code over a flat board.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] i_board_flat,
    input  logic [1:0]  i_player,
    output logic        o_win
);

    logic [8:0] w_own;

    for (genvar g = 0; g < 9; g++) begin : g_own
        assign w_own[g] = (i_board_flat[2*g +: 2] == i_player);
    end

    assign o_win = (w_own[0] & w_own[1] & w_own[2]) |
                   (w_own[3] & w_own[4] & w_own[5]) |
                   (w_own[6] & w_own[7] & w_own[8]) |
                   (w_own[0] & w_own[3] & w_own[6]) |
                   (w_own[1] & w_own[4] & w_own[7]) |
                   (w_own[2] & w_own[5] & w_own[8]) |
                   (w_own[0] & w_own[4] & w_own[8]) |
                   (w_own[2] & w_own[4] & w_own[6]);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the board, applies validated moves,
// alternates turns and reports win/draw.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER   = 1'b0,
    parameter logic CHECK_OCCUPIED = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_new_game,
    input  logic        i_move_vld,
    input  logic [1:0]  i_move_row,
    input  logic [1:0]  i_move_col,
    output logic        o_move_rdy,
    output logic        o_move_err,
    output logic [17:0] o_board_flat,
    output logic        o_turn,
    output logic        o_game_over,
    output logic [1:0]  o_winner,
    output logic [3:0]  o_move_cnt,
    output logic [1:0]  o_state
);

    // Handshake: a move transfers on a rising edge where i_move_vld and
    // o_move_rdy are both high; vld without rdy is dropped, never queued.

    state_t      r_state,    w_state_nxt;
    logic [17:0] r_board,    w_board_nxt;
    logic        r_turn,     w_turn_nxt;
    logic [3:0]  r_move_cnt, w_cnt_nxt;
    logic [1:0]  r_winner,   w_winner_nxt;
    logic        r_move_err, w_err_nxt;
    logic [1:0]  r_row,      w_row_nxt;
    logic [1:0]  r_col,      w_col_nxt;

    logic        w_in_range;
    logic [3:0]  w_idx;
    logic [1:0]  w_cell;
    logic [1:0]  w_turn_code;
    logic        w_reject;
    logic        w_win;

    assign w_in_range  = (r_row <= 2'd2) && (r_col <= 2'd2);
    assign w_idx       = w_in_range ? cell_idx(r_row, r_col) : 4'd0;
    assign w_cell      = r_board[{w_idx, 1'b0} +: 2];
    assign w_turn_code = {1'b0, r_turn};
    assign w_reject    = !w_in_range || (CHECK_OCCUPIED && (w_cell != CELL_EMPTY));

    ttt_line_check u_line_check (
        .i_board_flat (r_board),
        .i_player     (w_turn_code),
        .o_win        (w_win)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_board_nxt  = r_board;
        w_turn_nxt   = r_turn;
        w_cnt_nxt    = r_move_cnt;
        w_winner_nxt = r_winner;
        w_err_nxt    = 1'b0;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;

        case (r_state)
            S_WAIT_MOVE: begin
                if (i_move_vld) begin
                    w_row_nxt   = i_move_row;
                    w_col_nxt   = i_move_col;
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                if (w_reject) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_MOVE;
                end else begin
                    w_board_nxt[{w_idx, 1'b0} +: 2] = w_turn_code;
                    if (r_move_cnt < MAX_MOVES) begin
                        w_cnt_nxt = r_move_cnt + 4'd1;
                    end
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // Win is tested before the full-board draw so a 9th-move win wins.
                if (w_win) begin
                    w_winner_nxt = w_turn_code;
                    w_state_nxt  = S_DONE;
                end else if (r_move_cnt == MAX_MOVES) begin
                    w_winner_nxt = WIN_DRAW;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_turn_nxt  = ~r_turn;
                    w_state_nxt = S_WAIT_MOVE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_WAIT_MOVE;
            end
        endcase

        if (i_new_game) begin
            w_state_nxt  = S_WAIT_MOVE;
            w_board_nxt  = BOARD_EMPTY;
            w_turn_nxt   = FIRST_PLAYER;
            w_cnt_nxt    = 4'd0;
            w_winner_nxt = WIN_NONE;
            w_err_nxt    = 1'b0;
            w_row_nxt    = 2'd0;
            w_col_nxt    = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT_MOVE;
            r_board    <= BOARD_EMPTY;
            r_turn     <= FIRST_PLAYER;
            r_move_cnt <= 4'd0;
            r_winner   <= WIN_NONE;
            r_move_err <= 1'b0;
            r_row      <= 2'd0;
            r_col      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_board    <= w_board_nxt;
            r_turn     <= w_turn_nxt;
            r_move_cnt <= w_cnt_nxt;
            r_winner   <= w_winner_nxt;
            r_move_err <= w_err_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
        end
    end

    assign o_move_rdy   = (r_state == S_WAIT_MOVE);
    assign o_game_over  = (r_state == S_DONE);
    assign o_move_err   = r_move_err;
    assign o_board_flat = r_board;
    assign o_turn       = r_turn;
    assign o_winner     = r_winner;
    assign o_move_cnt   = r_move_cnt;
    assign o_state      = r_state;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: table of per-move expectations plus
// hand-written sequences for held valid, new_game and asynchronous reset.
module tb_ttt_game_ctrl;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic        move_vld;
    logic [1:0]  move_row;
    logic [1:0]  move_col;
    logic        move_rdy;
    logic        move_err;
    logic [17:0] board_flat;
    logic        turn;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  move_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    localparam logic [17:0] EMPTY = 18'h2AAAA;

    typedef struct {
        logic       ng;
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] mover;
        logic       exp_err;
        logic       exp_turn;
        logic [3:0] exp_cnt;
        logic [1:0] exp_win;
        logic       exp_over;
    } vec_t;

    vec_t        vecs[$];
    logic [17:0] exp_board;

    ttt_game_ctrl #(
        .FIRST_PLAYER   (1'b0),
        .CHECK_OCCUPIED (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_new_game   (new_game),
        .i_move_vld   (move_vld),
        .i_move_row   (move_row),
        .i_move_col   (move_col),
        .o_move_rdy   (move_rdy),
        .o_move_err   (move_err),
        .o_board_flat (board_flat),
        .o_turn       (turn),
        .o_game_over  (game_over),
        .o_winner     (winner),
        .o_move_cnt   (move_cnt),
        .o_state      (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy;
        int n;
        n = 0;
        while (move_rdy !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        chk("wait_rdy", 32'(move_rdy), 32'd1);
    endtask

    task automatic pulse_ng;
        new_game = 1'b1;
        step;
        new_game = 1'b0;
    endtask

    // Presents a move for one edge; returns in cycle N+1.
    task automatic send(input int r, input int c);
        move_row = r[1:0];
        move_col = c[1:0];
        move_vld = 1'b1;
        step;
        move_vld = 1'b0;
    endtask

    task automatic add(input logic ng, input int row, input int col, input int mover,
                       input int err, input int trn, input int cnt, input int win, input int over);
        vec_t v;
        v.ng       = ng;
        v.row      = row[1:0];
        v.col      = col[1:0];
        v.mover    = mover[1:0];
        v.exp_err  = err[0];
        v.exp_turn = trn[0];
        v.exp_cnt  = cnt[3:0];
        v.exp_win  = win[1:0];
        v.exp_over = over[0];
        vecs.push_back(v);
    endtask

    initial begin
        int idx;
        int rr[5];
        int cc[5];

        rst_n    = 1'b0;
        new_game = 1'b0;
        move_vld = 1'b0;
        move_row = 2'd0;
        move_col = 2'd0;
        exp_board = EMPTY;

        // X wins on the top row
        add(1, 0, 0, 0, 0, 1, 1, 3, 0);
        add(0, 1, 1, 1, 0, 0, 2, 3, 0);
        add(0, 0, 1, 0, 0, 1, 3, 3, 0);
        add(0, 2, 2, 1, 0, 0, 4, 3, 0);
        add(0, 0, 2, 0, 0, 0, 5, 0, 1);
        // occupied cell and out-of-range moves, then a legal O move
        add(1, 1, 1, 0, 0, 1, 1, 3, 0);
        add(0, 1, 1, 1, 1, 1, 1, 3, 0);
        add(0, 3, 0, 1, 1, 1, 1, 3, 0);
        add(0, 0, 3, 1, 1, 1, 1, 3, 0);
        add(0, 2, 0, 1, 0, 0, 2, 3, 0);
        // full drawn game
        add(1, 0, 0, 0, 0, 1, 1, 3, 0);
        add(0, 0, 1, 1, 0, 0, 2, 3, 0);
        add(0, 0, 2, 0, 0, 1, 3, 3, 0);
        add(0, 1, 1, 1, 0, 0, 4, 3, 0);
        add(0, 1, 0, 0, 0, 1, 5, 3, 0);
        add(0, 1, 2, 1, 0, 0, 6, 3, 0);
        add(0, 2, 1, 0, 0, 1, 7, 3, 0);
        add(0, 2, 0, 1, 0, 0, 8, 3, 0);
        add(0, 2, 2, 0, 0, 0, 9, 2, 1);
        // X wins on the 9th move via the main diagonal
        add(1, 0, 0, 0, 0, 1, 1, 3, 0);
        add(0, 0, 2, 1, 0, 0, 2, 3, 0);
        add(0, 1, 1, 0, 0, 1, 3, 3, 0);
        add(0, 2, 0, 1, 0, 0, 4, 3, 0);
        add(0, 0, 1, 0, 0, 1, 5, 3, 0);
        add(0, 2, 1, 1, 0, 0, 6, 3, 0);
        add(0, 1, 2, 0, 0, 1, 7, 3, 0);
        add(0, 1, 0, 1, 0, 0, 8, 3, 0);
        add(0, 2, 2, 0, 0, 0, 9, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_board", 32'(board_flat), 32'(EMPTY));
        chk("rst_turn", 32'(turn), 32'd0);
        chk("rst_cnt", 32'(move_cnt), 32'd0);
        chk("rst_winner", 32'(winner), 32'd3);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_err", 32'(move_err), 32'd0);
        rst_n = 1'b1;
        step;
        chk("rst_rdy", 32'(move_rdy), 32'd1);

        foreach (vecs[k]) begin
            if (vecs[k].ng) begin
                pulse_ng;
                exp_board = EMPTY;
            end
            wait_rdy;
            send(int'(vecs[k].row), int'(vecs[k].col));
            chk("apply_rdy", 32'(move_rdy), 32'd0);
            step;
            chk("err_n2", 32'(move_err), 32'(vecs[k].exp_err));
            chk("rdy_n2", 32'(move_rdy), 32'(vecs[k].exp_err));
            if (!vecs[k].exp_err) begin
                idx = int'(vecs[k].row) * 3 + int'(vecs[k].col);
                exp_board[2*idx +: 2] = vecs[k].mover;
            end
            step;
            chk("err_n3", 32'(move_err), 32'd0);
            chk("turn", 32'(turn), 32'(vecs[k].exp_turn));
            chk("cnt", 32'(move_cnt), 32'(vecs[k].exp_cnt));
            chk("winner", 32'(winner), 32'(vecs[k].exp_win));
            chk("over", 32'(game_over), 32'(vecs[k].exp_over));
            chk("board", 32'(board_flat), 32'(exp_board));
            chk("rdy_n3", 32'(move_rdy), 32'(!vecs[k].exp_over));
        end

        // move_vld held through APPLY and CHECK takes only one move
        pulse_ng;
        wait_rdy;
        move_row = 2'd2;
        move_col = 2'd2;
        move_vld = 1'b1;
        step;
        step;
        step;
        move_vld = 1'b0;
        chk("hold_cnt", 32'(move_cnt), 32'd1);
        chk("hold_state", 32'(state), 32'd0);
        chk("hold_turn", 32'(turn), 32'd1);
        step;
        step;
        chk("hold_cnt_later", 32'(move_cnt), 32'd1);

        // quick X win, then move_vld held in DONE
        rr = '{0, 1, 0, 2, 0};
        cc = '{0, 1, 1, 2, 2};
        pulse_ng;
        for (int i = 0; i < 5; i++) begin
            wait_rdy;
            send(rr[i], cc[i]);
            step;
            step;
        end
        chk("done_over", 32'(game_over), 32'd1);
        move_row = 2'd2;
        move_col = 2'd1;
        move_vld = 1'b1;
        repeat (4) step;
        chk("done_cnt", 32'(move_cnt), 32'd5);
        chk("done_cell7", 32'(board_flat[15:14]), 32'd2);
        chk("done_rdy", 32'(move_rdy), 32'd0);
        chk("done_state", 32'(state), 32'd3);
        move_vld = 1'b0;

        // new_game out of DONE
        pulse_ng;
        chk("ng_board", 32'(board_flat), 32'(EMPTY));
        chk("ng_winner", 32'(winner), 32'd3);
        chk("ng_turn", 32'(turn), 32'd0);
        chk("ng_cnt", 32'(move_cnt), 32'd0);
        chk("ng_over", 32'(game_over), 32'd0);
        chk("ng_rdy", 32'(move_rdy), 32'd1);

        // new_game during APPLY discards the captured move
        send(1, 1);
        new_game = 1'b1;
        step;
        new_game = 1'b0;
        chk("ng_apply_board", 32'(board_flat), 32'(EMPTY));
        chk("ng_apply_cnt", 32'(move_cnt), 32'd0);
        chk("ng_apply_state", 32'(state), 32'd0);
        step;
        chk("ng_apply_board2", 32'(board_flat), 32'(EMPTY));
        chk("ng_apply_err", 32'(move_err), 32'd0);

        // asynchronous reset in the middle of CHECK
        wait_rdy;
        send(0, 0);
        step;
        chk("pre_rst_state", 32'(state), 32'd2);
        chk("pre_rst_board", 32'(board_flat), 32'(EMPTY & ~18'h3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_board", 32'(board_flat), 32'(EMPTY));
        chk("arst_cnt", 32'(move_cnt), 32'd0);
        chk("arst_winner", 32'(winner), 32'd3);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_rdy", 32'(move_rdy), 32'd1);
        #2;
        rst_n = 1'b1;
        step;
        chk("post_rst_rdy", 32'(move_rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
